fp16_div_seq: RTL and testbench
===============================

// Module: fp16_div_seq
// PURPOSE
//  Iterative IEEE-754 half-precision divider (result = a / b), companion to the fp16 adder in the fp16 arithmetic library.
//  Restoring division, one quotient bit per cycle; valid/ready handshake on both sides; one operation in flight.
//  Numeric policy matches the fp16 adder: truncation (no rounding), flush-to-zero underflow, quiet NaN = NAN_VALUE.
// PARAMETERS
//  NAN_VALUE   16'h7E01  encoding returned for every NaN-producing case
//  QBITS       12        quotient bits generated (1 integer + 11 fraction); fixes DIV-state length
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst_n         in   1   reset, synchronous, active-low
//  in_valid      in   1   operands a/b valid
//  in_ready      out  1   divider idle, can accept operands
//  a             in   16  dividend, fp16 {sign, exp[4:0], mant[9:0]}
//  b             in   16  divisor, fp16
//  out_valid     out  1   result valid, held until out_ready
//  out_ready     in   1   consumer accepts result
//  result        out  16  quotient, fp16
//  div_by_zero   out  1   qualified by out_valid: finite nonzero a divided by zero b
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=16'h0000, div_by_zero=0; reset mid-operation aborts, result lost.
//  FSM IDLE -> (in_valid) -> DIV or DONE (special) ; DIV x QBITS -> NORM -> DONE -> (out_ready) -> IDLE.
//  in_ready = (state==IDLE) only; no accept while DONE even if out_ready=1 (no back-to-back overlap).
//  Accept (in_valid & in_ready): latch sign_q = a[15]^b[15], classify operands, go to DIV or DONE.
//  Denormal inputs (exp==0, mant!=0) are flushed to signed zero before classification.
//  Special cases (go straight to DONE, out_valid 1 cycle after accept), in priority order:
//   - a or b NaN, 0/0, inf/inf                      -> NAN_VALUE, div_by_zero=0
//   - a finite nonzero, b zero                      -> {sign_q,5'h1F,10'h0}, div_by_zero=1
//   - a inf (b finite incl. zero)                   -> {sign_q,5'h1F,10'h0}, div_by_zero=0
//   - a zero, or b inf                              -> {sign_q,15'h0}
//  Normal path: ma={1,a.mant}, mb={1,b.mant} (11b); remainder r(12b)=ma; e = a.exp - b.exp + 15 (signed 7b).
//  DIV, each cycle k=QBITS-1..0: if r>=mb {q[k]=1; r=r-mb} else q[k]=0; r=r<<1. Exactly QBITS cycles.
//  NORM: if q[11] {mant=q[10:1]} else {mant=q[9:0]; e=e-1}. Truncate; remainder discarded.
//   e>=31 -> {sign_q,5'h1F,10'h0}; e<=0 -> {sign_q,15'h0} (flush); else {sign_q,e[4:0],mant}.
//  Latency normal path: accept at edge N -> out_valid=1 after edge N+QBITS+2 (14 cycles default).
//  DONE: result/div_by_zero stable while out_valid=1 & out_ready=0; on out_valid&out_ready -> IDLE,
//   out_valid=0 next cycle, result holds last value (don't-care when out_valid=0).
//  in_valid while in_ready=0 ignored; a/b need not be held after accept.
// TESTING
//  1. a=3C00, b=4000 (1/2), out_ready=1 -> result 3800, out_valid exactly 14 cycles after accept, in_ready low meanwhile.
//  2. a=3C00, b=4200 (1/3) -> 3555 (truncated); a=BC00, b=4000 -> B800 (sign XOR).
//  3. a=3C00, b=0000 -> 7C00 div_by_zero=1 after 1 cycle; a=0000,b=0000 -> 7E01; a=7C00,b=7C00 -> 7E01; a=7E00,b=3C00 -> 7E01.
//  4. a=7BFF, b=1400 -> 7C00 (overflow); a=0400, b=7800 -> 0000 (underflow flush); a=0001,b=3C00 -> 0000 (denormal in).
//  5. out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_valid pulses ignored; release -> IDLE next cycle.
//  6. rst_n=0 during DIV cycle 6 -> next cycle out_valid=0, in_ready=1, result=0000; new op then completes correctly.

Source files
------------

// File: rtl/fp16_div_seq_if.sv
// Operand/result handshake bundle for the fp16 sequential divider.
// The master issues operands and consumes results; the slave is the divider.
interface fp16_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, div_by_zero
  );
endinterface

// File: rtl/fp16_div_seq.sv
// Iterative fp16 divider: restoring division, one quotient bit per cycle,
// truncating, flush-to-zero, single operation in flight.
module fp16_div_seq #(
  parameter logic [15:0] NAN_VALUE = 16'h7E01,
  parameter int          QBITS     = 12
) (
  input logic          clk,
  input logic          rst_n,
  fp16_div_seq_if.slave bus
);
  localparam int CW = $clog2(QBITS);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic               sign_r;
  logic [10:0]        mb_r;
  logic [11:0]        r_r;
  logic [QBITS-1:0]   q_r;
  logic signed [6:0]  e_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               dbz_r;
  logic [15:0]        result_r;

  logic               sign_in_s;
  logic               a_zero_s, a_inf_s, a_nan_s;
  logic               b_zero_s, b_inf_s, b_nan_s;
  logic               spec_hit_s;
  logic               spec_dbz_s;
  logic [15:0]        spec_res_s;
  logic               r_ge_s;
  logic [11:0]        r_sub_s;
  logic signed [6:0]  e_adj_s;
  logic [9:0]         mant_s;
  logic [15:0]        norm_res_s;

  // Denormals have exp==0, so treating any zero exponent as zero flushes them.
  function automatic logic is_zero(input logic [15:0] x);
    return (x[14:10] == 5'h00);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  assign sign_in_s = bus.a[15] ^ bus.b[15];
  assign a_zero_s  = is_zero(bus.a);
  assign a_inf_s   = is_inf(bus.a);
  assign a_nan_s   = is_nan(bus.a);
  assign b_zero_s  = is_zero(bus.b);
  assign b_inf_s   = is_inf(bus.b);
  assign b_nan_s   = is_nan(bus.b);

  // Special-operand classification, highest priority first.
  always_comb begin
    spec_hit_s = 1'b1;
    spec_dbz_s = 1'b0;
    spec_res_s = NAN_VALUE;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_res_s = NAN_VALUE;
    end else if (a_inf_s) begin
      spec_res_s = {sign_in_s, 5'h1F, 10'h000};
    end else if (b_zero_s) begin
      spec_res_s = {sign_in_s, 5'h1F, 10'h000};
      spec_dbz_s = 1'b1;
    end else if (a_zero_s || b_inf_s) begin
      spec_res_s = {sign_in_s, 15'h0000};
    end else begin
      spec_hit_s = 1'b0;
    end
  end

  assign r_ge_s  = (r_r >= {1'b0, mb_r});
  assign r_sub_s = r_ge_s ? (r_r - {1'b0, mb_r}) : r_r;

  // Normalise the quotient and pack, saturating to inf or flushing to zero.
  always_comb begin
    if (q_r[QBITS-1]) begin
      mant_s  = q_r[QBITS-2 -: 10];
      e_adj_s = e_r;
    end else begin
      mant_s  = q_r[QBITS-3 -: 10];
      e_adj_s = e_r - 7'sd1;
    end
    if (e_adj_s >= 7'sd31) begin
      norm_res_s = {sign_r, 5'h1F, 10'h000};
    end else if (e_adj_s <= 7'sd0) begin
      norm_res_s = {sign_r, 15'h0000};
    end else begin
      norm_res_s = {sign_r, e_adj_s[4:0], mant_s};
    end
  end

  // Control FSM and datapath registers; out_valid rises one cycle after DONE is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      sign_r      <= 1'b0;
      mb_r        <= 11'h000;
      r_r         <= 12'h000;
      q_r         <= '0;
      e_r         <= 7'sd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      dbz_r       <= 1'b0;
      result_r    <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            sign_r     <= sign_in_s;
            if (spec_hit_s) begin
              result_r <= spec_res_s;
              dbz_r    <= spec_dbz_s;
              state_r  <= DONE;
            end else begin
              mb_r    <= {1'b1, bus.b[9:0]};
              r_r     <= {2'b01, bus.a[9:0]};
              q_r     <= '0;
              e_r     <= $signed({2'b00, bus.a[14:10]}) - $signed({2'b00, bus.b[14:10]}) + 7'sd15;
              cnt_r   <= CW'(QBITS - 1);
              dbz_r   <= 1'b0;
              state_r <= DIV;
            end
          end
        end
        DIV: begin
          q_r <= {q_r[QBITS-2:0], r_ge_s};
          r_r <= r_sub_s << 1;
          if (cnt_r == '0) begin
            state_r <= NORM;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        NORM: begin
          result_r <= norm_res_s;
          state_r  <= DONE;
        end
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.result      = result_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed bench for fp16_div_seq: expected results queued at issue time,
// checked by an independent monitor at each output handshake.
module tb_fp16_div_seq;
  logic clk;
  logic rst_n;
  int   total_cnt;
  int   bad_cnt;
  logic [16:0] exp_q[$];

  fp16_div_seq_if bif ();

  fp16_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act !== exp_v) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  // Scoreboard monitor: compare on every accepted result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bif.out_valid && bif.out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          bad_cnt++;
          $display("FAIL unexpected_output: got %h want none", bif.result);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("result", {16'h0, bif.result}, {16'h0, e[15:0]});
          chk("div_by_zero", {31'h0, bif.div_by_zero}, {31'h0, e[16]});
        end
      end
    end
  end

  task automatic start(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic [15:0] er, input logic ed, input logic push);
    int n = 0;
    while (!bif.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_issue", {31'h0, bif.in_ready}, 32'h1);
    bif.a        = ta;
    bif.b        = tb_v;
    bif.in_valid = 1'b1;
    if (push) exp_q.push_back({ed, er});
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    bif.a        = 16'($urandom);
    bif.b        = 16'($urandom);
  endtask

  task automatic wait_valid(input int lat);
    int   cyc = 0;
    logic ir_seen = 1'b0;
    while (!bif.out_valid && cyc < 40) begin
      ir_seen = ir_seen | bif.in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("in_ready_low_busy", {31'h0, ir_seen}, 32'h0);
  endtask

  logic [15:0] va [14] = '{16'h3C00, 16'h3C00, 16'hBC00, 16'h4500, 16'h3C00, 16'h0000, 16'h7C00,
                           16'h7E00, 16'h7BFF, 16'h0400, 16'h0001, 16'h7C00, 16'h3C00, 16'hC200};
  logic [15:0] vb [14] = '{16'h4000, 16'h4200, 16'h4000, 16'h3C00, 16'h0000, 16'h0000, 16'h7C00,
                           16'h3C00, 16'h1400, 16'h7800, 16'h3C00, 16'h0000, 16'hFC00, 16'h0000};
  logic [15:0] vr [14] = '{16'h3800, 16'h3555, 16'hB800, 16'h4500, 16'h7C00, 16'h7E01, 16'h7E01,
                           16'h7E01, 16'h7C00, 16'h0000, 16'h0000, 16'h7C00, 16'h8000, 16'hFC00};
  logic       vd [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int         vl [14] = '{14, 14, 14, 14, 1, 1, 1, 1, 14, 14, 1, 1, 1, 1};

  initial begin
    total_cnt     = 0;
    bad_cnt       = 0;
    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.a         = 16'h0000;
    bif.b         = 16'h0000;
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'h0, bif.in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, bif.out_valid}, 32'h0);
    chk("rst_result", {16'h0, bif.result}, 32'h0);
    chk("rst_dbz", {31'h0, bif.div_by_zero}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      start(va[i], vb[i], vr[i], vd[i], 1'b1);
      wait_valid(vl[i]);
      @(posedge clk); #1;
      chk("post_hs_out_valid", {31'h0, bif.out_valid}, 32'h0);
      chk("post_hs_in_ready", {31'h0, bif.in_ready}, 32'h1);
    end

    // Back-pressure: result held, new operands ignored while DONE.
    bif.out_ready = 1'b0;
    start(16'h3C00, 16'h4000, 16'h3800, 1'b0, 1'b1);
    wait_valid(14);
    for (int k = 0; k < 5; k++) begin
      bif.in_valid = 1'b1;
      bif.a        = 16'h3C00;
      bif.b        = 16'h4200;
      @(posedge clk); #1;
      chk("bp_out_valid", {31'h0, bif.out_valid}, 32'h1);
      chk("bp_result", {16'h0, bif.result}, 32'h3800);
      chk("bp_in_ready", {31'h0, bif.in_ready}, 32'h0);
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {31'h0, bif.out_valid}, 32'h0);
    chk("bp_release_in_ready", {31'h0, bif.in_ready}, 32'h1);

    // Reset in the middle of DIV aborts the operation.
    start(16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'h0, bif.out_valid}, 32'h0);
    chk("midrst_in_ready", {31'h0, bif.in_ready}, 32'h1);
    chk("midrst_result", {16'h0, bif.result}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start(16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b1);
    wait_valid(14);
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
